quat_cand_select: RTL and testbench
===================================

// Module: quat_cand_select
// PURPOSE
//   Quarter-pel decision stage of FME; consumes the 9 quarter-pel candidate pixels produced around the best half-pel point.
//   Accumulates one SAD per candidate over a block streamed one pixel position per beat, then scans the 9 SADs.
//   Returns the winning candidate index, its SAD and the final fractional MV (quarter-pel units) to the ME controller.
// PARAMETERS
//   PIX_W    8    pixel width
//   BLK_PIX  16   pixel positions per block (4x4); beats per block
//   SAD_W    12   SAD accumulator width; full range needs >= PIX_W+clog2(BLK_PIX)
// PORTS
//   clk         in   1            clock; all logic on posedge
//   rst         in   1            synchronous, active-high reset
//   in_valid    in   1            beat valid
//   in_ready    out  1            beat accepted when in_valid & in_ready
//   cur_pix     in   PIX_W        current-block pixel for this position
//   quat_pix    in   [8:0][PIX_W-1:0]  9 quarter-pel candidate pixels, same position
//   best_half   in   4            best half-pel index 0..8 (3x3 raster); sampled on first beat only
//   out_valid   out  1            result valid
//   out_ready   in   1            result consumed when out_valid & out_ready
//   best_q      out  4            winning quarter-pel index 0..8 (3x3 raster, 4 = centre)
//   best_sad    out  SAD_W        SAD of winner
//   mv_frac_x   out  3            signed fractional MV x, quarter-pel, -3..+3
//   mv_frac_y   out  3            signed fractional MV y, quarter-pel, -3..+3
// BEHAVIOUR
//   - Reset: state ACCUM, beat count 0, all 9 SADs 0, out_valid 0, best_q 0, best_sad 0, mv_frac_x/y 0. Reset mid-block discards all partial SADs.
//   - in_ready = (state==ACCUM) & ~rst; out_valid high only in DONE.
//   - ACCUM: per accepted beat, sad[i] += |quat_pix[i]-cur_pix| (unsigned, zero-extended), i=0..8 in parallel.
//     - sad[i] saturates at all-ones if SAD_W is undersized; no wrap.
//     - Beat count 0: latch best_half; values 9..15 treated as 0, same as the quarter-pel interpolator default.
//     - Accepting beat BLK_PIX-1 -> COMPARE, scan idx=0.
//     - in_valid low: hold state and count.
//   - COMPARE: one candidate per cycle, idx 0..8 (9 cycles).
//     - idx 0 loads min unconditionally; later idx replace min only if sad[idx] < min (strict), so ties go to the lowest index.
//     - After idx 8 -> DONE.
//   - DONE: outputs stable while out_valid=1 & out_ready=0. On handshake: clear SADs and count, -> ACCUM.
//     - in_ready becomes 1 the cycle after the handshake.
//   - Latency: last beat accepted in cycle T -> out_valid first high in cycle T+10.
//   - MV: qx=(best_q%3)-1, qy=(best_q/3)-1; hx=((best_half%3)-1)*2, hy=((best_half/3)-1)*2.
//     - mv_frac_x = hx+qx, mv_frac_y = hy+qy; 3-bit two's complement.
//   - No beat is accepted in COMPARE/DONE; an in_valid held high there is not lost, it waits.
// TESTING
//   - cur=50 all beats; quat[6]=50, others 60; best_half=4 -> best_q=6, best_sad=0, mv=(-1,+1).
//   - Tie: all candidates = cur -> best_q=0, best_sad=0; with best_half=8 -> mv=(+1,+1).
//   - cur=0, quat=255 except quat[8]=254; best_half=0 -> best_q=8, best_sad=4064, mv=(-1,-1); no saturation.
//   - Random in_valid gaps -> out_valid exactly 10 cycles after the last accepted beat; result matches a software model.
//   - out_ready low 5 cycles in DONE -> outputs held, in_ready=0. Next block is unaffected by the previous one.
//   - rst pulsed after 7 beats, then a full block of test 1 -> identical result to test 1; out_valid=0 during and after reset.

Source files
------------

// File: rtl/quat_cand_select_if.sv
// Handshake/bus bundle for the quarter-pel candidate selector.
// master: the beat source and result consumer (drives pixels, beat valid, result ready).
// slave : the selector (drives in_ready and the registered result).
//   in_valid/in_ready   beat handshake
//   cur_pix             current-block pixel for this position
//   quat_pix            9 quarter-pel candidate pixels, same position
//   best_half           best half-pel index 0..8, only meaningful on the first beat
//   out_valid/out_ready result handshake
//   best_q, best_sad    winning quarter-pel index and its SAD
//   mv_frac_x/y         signed fractional MV in quarter-pel units
interface quat_cand_select_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned SAD_W = 12
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [PIX_W-1:0]      cur_pix;
    logic [8:0][PIX_W-1:0] quat_pix;
    logic [3:0]            best_half;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            best_q;
    logic [SAD_W-1:0]      best_sad;
    logic [2:0]            mv_frac_x;
    logic [2:0]            mv_frac_y;

    modport master (
        output in_valid, cur_pix, quat_pix, best_half, out_ready,
        input  in_ready, out_valid, best_q, best_sad, mv_frac_x, mv_frac_y
    );

    modport slave (
        input  in_valid, cur_pix, quat_pix, best_half, out_ready,
        output in_ready, out_valid, best_q, best_sad, mv_frac_x, mv_frac_y
    );

endinterface

// File: rtl/quat_cand_select.sv
// Quarter-pel decision stage of fractional motion estimation.
// Accumulates one SAD per quarter-pel candidate over a block streamed one
// pixel position per beat, scans the 9 SADs one per cycle, then holds the
// winning index, its SAD and the combined half+quarter fractional MV until
// the consumer takes it.
//   clk  clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  quat_cand_select_if slave: beat input and result output
module quat_cand_select #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned BLK_PIX = 16,
    parameter int unsigned SAD_W   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    quat_cand_select_if.slave     bus
);

    localparam int unsigned N_CAND = 9;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;

    typedef enum logic [1:0] {
        S_ACCUM   = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]              cnt_q;
    logic [IDX_W-1:0]              idx_q;
    logic [N_CAND-1:0][SAD_W-1:0]  sad_q;
    logic [N_CAND-1:0][SAD_W-1:0]  sad_acc;
    logic [N_CAND-1:0][PIX_W-1:0]  abs_diff;
    logic [N_CAND-1:0][SAD_W:0]    sad_sum;
    logic [3:0]                    half_q;
    logic [3:0]                    half_eff;
    logic [SAD_W-1:0]              min_sad_q;
    logic [IDX_W-1:0]              min_idx_q;

    logic                          out_valid_q;
    logic [3:0]                    best_q_q;
    logic [SAD_W-1:0]              best_sad_q;
    logic [2:0]                    mv_x_q;
    logic [2:0]                    mv_y_q;

    logic                          in_ready_c;
    logic                          accept;
    logic                          last_beat;
    logic                          scan_last;
    logic                          handshake;
    logic [SAD_W-1:0]              cand_sad;
    logic                          cand_wins;
    logic [SAD_W-1:0]              win_sad;
    logic [IDX_W-1:0]              win_idx;
    logic [3:0]                    mv_x_w;
    logic [3:0]                    mv_y_w;

    // 3x3 raster column / row of an index; out-of-range indices map to 0
    function automatic logic [1:0] col3(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd4, 4'd7: col3 = 2'd1;
            4'd2, 4'd5, 4'd8: col3 = 2'd2;
            default:          col3 = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] row3(input logic [3:0] idx);
        case (idx)
            4'd3, 4'd4, 4'd5: row3 = 2'd1;
            4'd6, 4'd7, 4'd8: row3 = 2'd2;
            default:          row3 = 2'd0;
        endcase
    endfunction

    // Beat acceptance is blocked in the same cycle reset is asserted
    assign in_ready_c    = (state_q == S_ACCUM) & ~rst;
    assign accept        = bus.in_valid & in_ready_c;
    assign last_beat     = (cnt_q == CNT_W'(BLK_PIX - 1));
    assign scan_last     = (idx_q == IDX_W'(N_CAND - 1));
    assign handshake     = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.best_q    = best_q_q;
    assign bus.best_sad  = best_sad_q;
    assign bus.mv_frac_x = mv_x_q;
    assign bus.mv_frac_y = mv_y_q;

    // Out-of-range half-pel indices fall back to 0, matching the interpolator
    assign half_eff = (bus.best_half > 4'd8) ? 4'd0 : bus.best_half;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACCUM:   if (accept && last_beat) state_d = S_COMPARE;
            S_COMPARE: if (scan_last)           state_d = S_DONE;
            S_DONE:    if (handshake)           state_d = S_ACCUM;
            default:                            state_d = S_ACCUM;
        endcase
    end

    // Per-candidate absolute difference and saturating accumulate
    always_comb begin
        abs_diff = '0;
        sad_sum  = '0;
        sad_acc  = '0;
        for (int i = 0; i < int'(N_CAND); i++) begin
            abs_diff[i] = (bus.quat_pix[i] >= bus.cur_pix) ? (bus.quat_pix[i] - bus.cur_pix)
                                                           : (bus.cur_pix - bus.quat_pix[i]);
            sad_sum[i]  = {1'b0, sad_q[i]} + (SAD_W+1)'(abs_diff[i]);
            sad_acc[i]  = sad_sum[i][SAD_W] ? {SAD_W{1'b1}} : sad_sum[i][SAD_W-1:0];
        end
    end

    // Scan step: strict less-than keeps the lowest index on ties
    always_comb begin
        cand_sad = '0;
        for (int i = 0; i < int'(N_CAND); i++) begin
            if (idx_q == IDX_W'(i)) cand_sad = sad_q[i];
        end
        cand_wins = (idx_q == '0) || (cand_sad < min_sad_q);
        win_sad   = cand_wins ? cand_sad : min_sad_q;
        win_idx   = cand_wins ? idx_q    : min_idx_q;
    end

    // MV = 2*(half offset) + quarter offset, each offset being col/row - 1
    always_comb begin
        mv_x_w = 4'({col3(half_q), 1'b0}) + 4'(col3(win_idx)) - 4'd3;
        mv_y_w = 4'({row3(half_q), 1'b0}) + 4'(row3(win_idx)) - 4'd3;
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ACCUM;
            cnt_q       <= '0;
            idx_q       <= '0;
            sad_q       <= '0;
            half_q      <= '0;
            min_sad_q   <= '0;
            min_idx_q   <= '0;
            out_valid_q <= 1'b0;
            best_q_q    <= '0;
            best_sad_q  <= '0;
            mv_x_q      <= '0;
            mv_y_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        sad_q <= sad_acc;
                        if (cnt_q == '0) half_q <= half_eff;
                        if (last_beat) begin
                            cnt_q <= '0;
                            idx_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_COMPARE: begin
                    min_sad_q <= win_sad;
                    min_idx_q <= win_idx;
                    idx_q     <= idx_q + IDX_W'(1);
                    if (scan_last) begin
                        out_valid_q <= 1'b1;
                        best_q_q    <= win_idx;
                        best_sad_q  <= win_sad;
                        mv_x_q      <= mv_x_w[2:0];
                        mv_y_q      <= mv_y_w[2:0];
                    end
                end
                S_DONE: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        sad_q       <= '0;
                        cnt_q       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quat_cand_select.sv
// Self-checking bench for quat_cand_select: scoreboard of expected results,
// one task per scenario.
module tb_quat_cand_select;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned BLK_PIX = 16;
    localparam int unsigned SAD_W   = 12;

    typedef struct packed {
        logic [3:0]       q;
        logic [SAD_W-1:0] sad;
        logic [2:0]       mx;
        logic [2:0]       my;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;

    exp_t exp_q[$];

    logic [PIX_W-1:0] cur_blk [BLK_PIX];
    logic [PIX_W-1:0] q_blk   [BLK_PIX][9];

    quat_cand_select_if #(.PIX_W(PIX_W), .SAD_W(SAD_W)) bus ();

    quat_cand_select #(
        .PIX_W   (PIX_W),
        .BLK_PIX (BLK_PIX),
        .SAD_W   (SAD_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Reference: SAD per candidate, strict-min scan, MV from raster offsets
    function automatic exp_t model(input logic [3:0] bh);
        int   sad [9];
        int   best;
        int   h;
        int   mx;
        int   my;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            sad[i] = 0;
            for (int b = 0; b < int'(BLK_PIX); b++) begin
                int d;
                d = int'(q_blk[b][i]) - int'(cur_blk[b]);
                if (d < 0) d = -d;
                sad[i] += d;
            end
            if (sad[i] > 4095) sad[i] = 4095;
        end
        best = 0;
        for (int i = 1; i < 9; i++) if (sad[i] < sad[best]) best = i;
        h  = (int'(bh) > 8) ? 0 : int'(bh);
        mx = ((h % 3) - 1) * 2 + (best % 3) - 1;
        my = ((h / 3) - 1) * 2 + (best / 3) - 1;
        e.q   = 4'(best);
        e.sad = SAD_W'(sad[best]);
        e.mx  = 3'(mx);
        e.my  = 3'(my);
        return e;
    endfunction

    function automatic exp_t mk_exp(input int q, input int sad, input int mx, input int my);
        exp_t e;
        e.q   = 4'(q);
        e.sad = SAD_W'(sad);
        e.mx  = 3'(mx);
        e.my  = 3'(my);
        return e;
    endfunction

    task automatic fill_const(input int cur, input int others, input int idx, input int val);
        for (int b = 0; b < int'(BLK_PIX); b++) begin
            cur_blk[b] = PIX_W'(cur);
            for (int i = 0; i < 9; i++) q_blk[b][i] = (i == idx) ? PIX_W'(val) : PIX_W'(others);
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < int'(BLK_PIX); b++) begin
            cur_blk[b] = PIX_W'($urandom_range(255));
            for (int i = 0; i < 9; i++) q_blk[b][i] = PIX_W'($urandom_range(255));
        end
    endtask

    // Streams nbeats positions from the block arrays; best_half is random after beat 0
    task automatic drive_block(input int nbeats, input logic [3:0] bh, input int gap_pct);
        int b;
        int guard;
        b = 0;
        guard = 0;
        while (b < nbeats && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid  = 1'b1;
                bus.cur_pix   = cur_blk[b];
                for (int i = 0; i < 9; i++) bus.quat_pix[i] = q_blk[b][i];
                bus.best_half = (b == 0) ? bh : 4'($urandom_range(15));
                if (bus.in_ready === 1'b1) begin
                    last_acc = cyc;
                    b++;
                end
            end
        end
        checks++;
        if (b != nbeats) begin
            errors++;
            $display("FAIL drive_beats got %0d required %0d", b, nbeats);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = cyc - last_acc;
    endtask

    task automatic do_handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 0", bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b required 0", bus.out_valid);
        end
        checks++;
        if ({bus.best_q, bus.best_sad, bus.mv_frac_x, bus.mv_frac_y} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got q=%0d sad=%0d mx=%0d my=%0d required all 0",
                     bus.best_q, bus.best_sad, bus.mv_frac_x, bus.mv_frac_y);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_directed(input string name, input logic [3:0] bh);
        int   lat;
        bit   ok;
        exp_t e;
        exp_t got;
        drive_block(int'(BLK_PIX), bh, 0);
        wait_result(lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout out_valid never rose", name);
            return;
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL %s_latency got %0d required 10", name, lat);
        end
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        got = {bus.best_q, bus.best_sad, bus.mv_frac_x, bus.mv_frac_y};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s_result got q=%0d sad=%0d mx=%0d my=%0d required q=%0d sad=%0d mx=%0d my=%0d",
                     name, got.q, got.sad, $signed(got.mx), $signed(got.my),
                     e.q, e.sad, $signed(e.mx), $signed(e.my));
        end
        do_handshake();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_post_handshake got out_valid=%b in_ready=%b required 0/1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        fill_const(50, 60, 6, 50);
        exp_q.push_back(mk_exp(6, 0, -1, 1));
        test_directed("basic", 4'd4);
    endtask

    task automatic test_tie();
        fill_const(77, 77, 0, 77);
        exp_q.push_back(mk_exp(0, 0, 1, 1));
        test_directed("tie", 4'd8);
    endtask

    task automatic test_max_sad();
        fill_const(0, 255, 8, 254);
        exp_q.push_back(mk_exp(8, 4064, -1, -1));
        test_directed("max_sad", 4'd0);
    endtask

    task automatic test_random_gaps();
        int   lat;
        bit   ok;
        exp_t e;
        exp_t got;
        logic [3:0] bh;
        for (int n = 0; n < 5; n++) begin
            fill_random();
            bh = 4'($urandom_range(15));
            exp_q.push_back(model(bh));
            drive_block(int'(BLK_PIX), bh, 35);
            wait_result(lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_timeout block %0d", n);
                return;
            end
            checks++;
            if (lat != 10) begin
                errors++;
                $display("FAIL random_latency block %0d got %0d required 10", n, lat);
            end
            e   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            got = {bus.best_q, bus.best_sad, bus.mv_frac_x, bus.mv_frac_y};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL random_result block %0d got q=%0d sad=%0d mx=%0d my=%0d required q=%0d sad=%0d mx=%0d my=%0d",
                         n, got.q, got.sad, $signed(got.mx), $signed(got.my),
                         e.q, e.sad, $signed(e.mx), $signed(e.my));
            end
            do_handshake();
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        bit   ok;
        exp_t e;
        exp_t got;
        fill_random();
        exp_q.push_back(model(4'd5));
        drive_block(int'(BLK_PIX), 4'd5, 0);
        wait_result(lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL backpressure_timeout out_valid never rose");
            return;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        // in_valid held high with junk while the result is stalled; nothing may be taken
        bus.in_valid = 1'b1;
        bus.cur_pix  = 8'd200;
        for (int i = 0; i < 9; i++) bus.quat_pix[i] = 8'd3;
        for (int k = 0; k < 5; k++) begin
            got = {bus.best_q, bus.best_sad, bus.mv_frac_x, bus.mv_frac_y};
            checks++;
            if (got !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d got q=%0d sad=%0d v=%b rdy=%b required q=%0d sad=%0d v=1 rdy=0",
                         k, got.q, got.sad, bus.out_valid, bus.in_ready, e.q, e.sad);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        do_handshake();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_ready_after got %b required 1", bus.in_ready);
        end
        // Following block must not inherit any SAD from the previous one
        fill_const(30, 31, 3, 30);
        exp_q.push_back(mk_exp(3, 0, -1, 0));
        test_directed("after_backpressure", 4'd4);
    endtask

    task automatic test_reset_mid_block();
        fill_const(0, 0, 6, 255);
        drive_block(7, 4'd2, 0);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL midrst_during got out_valid=%b in_ready=%b required 0/0",
                         bus.out_valid, bus.in_ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after got out_valid=%b required 0", bus.out_valid);
        end
        fill_const(50, 60, 6, 50);
        exp_q.push_back(mk_exp(6, 0, -1, 1));
        test_directed("midrst_block", 4'd4);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cur_pix   = '0;
        bus.quat_pix  = '0;
        bus.best_half = '0;

        test_reset();
        test_basic();
        test_tie();
        test_max_sad();
        test_random_gaps();
        test_backpressure();
        test_reset_mid_block();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
